// File: rtl/sdm_alloc_pkg.sv
// Shared constants and types for the SDM switch allocator (port indices, input state, id width).
package sdm_alloc_pkg;

  localparam int PORT_S = 32'sd0;
  localparam int PORT_W = 32'sd1;
  localparam int PORT_N = 32'sd2;
  localparam int PORT_E = 32'sd3;
  localparam int PORT_L = 32'sd4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Width of an id that can name any of n sub-channels (at least one bit).
  function automatic int id_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// N-way round-robin arbiter: the pointer marks the highest-priority requester and
// moves just past the winner only when the caller confirms the grant with adv.
module rr_arb
  import sdm_alloc_pkg::*;
#(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] gnt
);

  localparam int W = id_width(N);

  logic [W-1:0]   ptr_r;
  logic [W-1:0]   win_s;
  logic [W-1:0]   nxt_s;
  logic [2*N-1:0] rot_s;
  logic           found_s;
  int             off_s;
  int             sum_s;

  // Rotate requests so the pointer sits at bit 0, take the first set bit, map back.
  always_comb begin
    rot_s   = {req, req} >> ptr_r;
    found_s = 1'b0;
    off_s   = 32'sd0;
    for (int k = 0; k < N; k++) begin
      if (!found_s && rot_s[k]) begin
        found_s = 1'b1;
        off_s   = k;
      end else begin
        found_s = found_s;
      end
    end
    sum_s = int'(ptr_r) + off_s;
    if (sum_s >= N) begin
      sum_s = sum_s - N;
    end else begin
      sum_s = sum_s;
    end
    win_s = W'(sum_s);
    nxt_s = (sum_s == N - 32'sd1) ? '0 : W'(sum_s + 32'sd1);
    for (int i = 0; i < N; i++) begin
      gnt[i] = found_s && (win_s == W'(i));
    end
  end

  // Pointer register; held unless a grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (adv && found_s) begin
      ptr_r <= nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/sdm_alloc_rr.sv
// SDM switch allocator: per-output-port round-robin over idle inputs, allocations held until rel.
// Build option: define SDM_ALLOC_UTURN_EN to make U-turn requests (target port == own port) legal.
module sdm_alloc_rr
  import sdm_alloc_pkg::*;
#(
  parameter  int P   = 5,
  parameter  int VCN = 2,
  localparam int NIO = P * VCN,
  localparam int IW  = id_width(P * VCN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [P*VCN-1:0][P-1:0]   req,
  input  logic [P*VCN-1:0]          rel,
  output logic [P*VCN-1:0]          ack,
  output logic [P*VCN-1:0][IW-1:0]  cfg,
  output logic [P*VCN-1:0]          cfg_vld,
  output logic                      err
);

  state_t                  state_r     [NIO];
  state_t                  state_nxt_s [NIO];
  logic [NIO-1:0]          onehot_s;
  logic [NIO-1:0]          uturn_s;
  logic [NIO-1:0]          idle_s;
  logic [NIO-1:0]          legal_s;
  logic [NIO-1:0]          bad_s;
  logic [NIO-1:0]          ack_r, ack_nxt_s;
  logic [NIO-1:0]          vld_r, vld_nxt_s;
  logic [NIO-1:0][IW-1:0]  cfg_r, cfg_nxt_s;
  logic                    err_r, err_nxt_s;
  logic [NIO-1:0]          cand_s [P];
  logic [NIO-1:0]          gnt_s  [P];
  logic [P-1:0]            free_s;
  logic [P-1:0]            adv_s;
  int                      free_vc_s [P];

  // Classify each idle input's request as legal, illegal or absent.
  always_comb begin
    for (int i = 0; i < NIO; i++) begin
      onehot_s[i] = ($countones(req[i]) == 32'sd1);
`ifdef SDM_ALLOC_UTURN_EN
      uturn_s[i]  = 1'b0;
`else
      uturn_s[i]  = req[i][i / VCN];
`endif
      idle_s[i]   = (state_r[i] == IDLE);
      legal_s[i]  = idle_s[i] & onehot_s[i] & ~uturn_s[i];
      bad_s[i]    = idle_s[i] & (|req[i]) & (~onehot_s[i] | uturn_s[i]);
    end
  end

  // Per output port: candidate inputs and lowest free sub-channel.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      for (int i = 0; i < NIO; i++) begin
        cand_s[p][i] = legal_s[i] & req[i][p];
      end
      free_s[p]    = 1'b0;
      free_vc_s[p] = 32'sd0;
      for (int v = VCN - 1; v >= 0; v--) begin
        if (!vld_r[p*VCN + v]) begin
          free_s[p]    = 1'b1;
          free_vc_s[p] = v;
        end else begin
          free_s[p]    = free_s[p];
        end
      end
      adv_s[p] = free_s[p] & (|cand_s[p]);
    end
  end

  for (genvar p = 0; p < P; p++) begin : g_port
    rr_arb #(.N(NIO)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (cand_s[p]),
      .adv   (adv_s[p]),
      .gnt   (gnt_s[p])
    );
  end

  // Next state: releases free the slot their owner holds; grants fill the chosen free slot.
  // Releases touch only held slots and grants only free ones, so the two never collide.
  always_comb begin
    ack_nxt_s   = '0;
    vld_nxt_s   = vld_r;
    cfg_nxt_s   = cfg_r;
    state_nxt_s = state_r;
    err_nxt_s   = err_r | (|bad_s);
    for (int i = 0; i < NIO; i++) begin
      if (rel[i] && (state_r[i] == BUSY)) begin
        state_nxt_s[i] = IDLE;
        for (int o = 0; o < NIO; o++) begin
          if (vld_r[o] && (cfg_r[o] == IW'(i))) begin
            vld_nxt_s[o] = 1'b0;
          end else begin
            vld_nxt_s[o] = vld_nxt_s[o];
          end
        end
      end else begin
        state_nxt_s[i] = state_nxt_s[i];
      end
    end
    for (int p = 0; p < P; p++) begin
      for (int i = 0; i < NIO; i++) begin
        if (adv_s[p] && gnt_s[p][i]) begin
          ack_nxt_s[i]                     = 1'b1;
          state_nxt_s[i]                   = BUSY;
          cfg_nxt_s[p*VCN + free_vc_s[p]]  = IW'(i);
          vld_nxt_s[p*VCN + free_vc_s[p]]  = 1'b1;
        end else begin
          ack_nxt_s[i]                     = ack_nxt_s[i];
        end
      end
    end
  end

  // State and output registers; reset drops every allocation immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r <= '0;
      vld_r <= '0;
      cfg_r <= '0;
      err_r <= 1'b0;
      for (int i = 0; i < NIO; i++) begin
        state_r[i] <= IDLE;
      end
    end else begin
      ack_r   <= ack_nxt_s;
      vld_r   <= vld_nxt_s;
      cfg_r   <= cfg_nxt_s;
      err_r   <= err_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  assign ack     = ack_r;
  assign cfg     = cfg_r;
  assign cfg_vld = vld_r;
  assign err     = err_r;

endmodule

// File: tb/tb_sdm_alloc_rr.sv
// Self-checking bench for sdm_alloc_rr: directed scenarios plus randomized traffic
// compared every cycle against a behavioural allocation model.
module tb_sdm_alloc_rr;

  localparam int P   = 5;
  localparam int VCN = 2;
  localparam int N   = P * VCN;
  localparam int IW  = $clog2(N);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N-1:0][P-1:0]   req;
  logic [N-1:0]          rel;
  logic [N-1:0]          ack;
  logic [N-1:0][IW-1:0]  cfg;
  logic [N-1:0]          cfg_vld;
  logic                  err;

  sdm_alloc_rr #(.P(P), .VCN(VCN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .rel     (rel),
    .ack     (ack),
    .cfg     (cfg),
    .cfg_vld (cfg_vld),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who is busy, who owns each output sub-channel, RR pointer per port.
  bit           m_busy  [N];
  int           m_owner [N];
  int           m_ptr   [P];
  bit           m_err;
  logic [N-1:0] m_ack;
  int           tgt     [N];
  bit           bad_ok;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i]  = 1'b0;
      m_owner[i] = -1;
    end
    for (int p = 0; p < P; p++) m_ptr[p] = 0;
    m_err = 1'b0;
    m_ack = '0;
  endtask

  function automatic bit legal_req(input int i);
    if ($countones(req[i]) != 1) return 1'b0;
`ifdef SDM_ALLOC_UTURN_EN
    return 1'b1;
`else
    return !req[i][i / VCN];
`endif
  endfunction

  function automatic int pick_tgt(input int i, input bit any);
    if (any) return $urandom_range(0, P - 1);
    return (i / VCN + 1 + $urandom_range(0, P - 2)) % P;
  endfunction

  // One clock of allocation semantics, from the current inputs and pre-edge model state.
  task automatic model_step();
    bit           nb [N];
    int           no [N];
    logic [N-1:0] a;
    a  = '0;
    nb = m_busy;
    no = m_owner;
    for (int i = 0; i < N; i++)
      if (!m_busy[i] && req[i] != '0 && !legal_req(i)) m_err = 1'b1;
    for (int p = 0; p < P; p++) begin
      int best, bestd, fr;
      best = -1; bestd = N; fr = -1;
      for (int i = 0; i < N; i++) begin
        if (!m_busy[i] && legal_req(i) && req[i][p]) begin
          int d;
          d = (i - m_ptr[p] + N) % N;
          if (d < bestd) begin bestd = d; best = i; end
        end
      end
      for (int v = VCN - 1; v >= 0; v--) if (m_owner[p*VCN + v] < 0) fr = v;
      if (best >= 0 && fr >= 0) begin
        a[best]          = 1'b1;
        nb[best]         = 1'b1;
        no[p*VCN + fr]   = best;
        m_ptr[p]         = (best + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (rel[i] && m_busy[i]) begin
        nb[i] = 1'b0;
        for (int o = 0; o < N; o++) if (m_owner[o] == i) no[o] = -1;
      end
    end
    m_busy  = nb;
    m_owner = no;
    m_ack   = a;
  endtask

  task automatic check_outputs();
    logic [N-1:0] ev;
    for (int o = 0; o < N; o++) ev[o] = (m_owner[o] >= 0);
    chk("ack", 64'(ack), 64'(m_ack));
    chk("cfg_vld", 64'(cfg_vld), 64'(ev));
    chk("err", 64'(err), 64'(m_err));
    for (int o = 0; o < N; o++)
      if (m_owner[o] >= 0) chk($sformatf("cfg%0d", o), 64'(cfg[o]), 64'(m_owner[o]));
  endtask

  // Called with inputs already driven at a negedge; ends at the next negedge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    for (int i = 0; i < N; i++) if (m_ack[i]) tgt[i] = pick_tgt(i, bad_ok);
    @(negedge clk);
  endtask

  task automatic gen_random();
    for (int i = 0; i < N; i++) begin
      rel[i] = 1'b0;
      req[i] = '0;
      if (m_busy[i]) begin
        rel[i] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) req[i] = P'($urandom);
      end else begin
        if ($urandom_range(0, 19) == 0) rel[i] = 1'b1;
        if ($urandom_range(0, 9) < 7) req[i][tgt[i]] = 1'b1;
        if (bad_ok && $urandom_range(0, 19) == 0) req[i] = P'($urandom);
      end
    end
  endtask

  initial begin
    bad_ok = 1'b0;
    for (int i = 0; i < N; i++) tgt[i] = pick_tgt(i, 1'b0);
    model_reset();

    // Reset holds everything at zero whatever the inputs do.
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) req[i] = P'($urandom);
      rel = N'($urandom);
      @(posedge clk);
      #1;
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_vld", 64'(cfg_vld), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
    end
    @(negedge clk);
    req = '0;
    rel = '0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ack", 64'(ack), 64'd0);
    chk("post_rst_vld", 64'(cfg_vld), 64'd0);

    // Input 0 requests E: granted on output 6, then released.
    req[0] = 5'b01000;
    tick();
    chk("t2_ack0", 64'(ack[0]), 64'd1);
    chk("t2_cfg6", 64'(cfg[6]), 64'd0);
    chk("t2_vld6", 64'(cfg_vld[6]), 64'd1);
    req[0] = '0;
    tick();
    rel[0] = 1'b1;
    tick();
    rel[0] = 1'b0;
    chk("t2_rel_vld6", 64'(cfg_vld[6]), 64'd0);

    // Three inputs contend for L with two sub-channels.
    req[0] = 5'b10000; req[2] = 5'b10000; req[4] = 5'b10000;
    tick();
    chk("t3_first", 64'(ack), 64'h001);
    req[0] = '0;
    tick();
    chk("t3_second", 64'(ack), 64'h004);
    req[2] = '0;
    tick();
    chk("t3_full", 64'(ack), 64'h000);
    rel[0] = 1'b1;
    tick();
    rel[0] = 1'b0;
    chk("t3_rel_noack", 64'(ack), 64'h000);
    tick();
    chk("t3_third", 64'(ack), 64'h010);
    chk("t3_cfg8", 64'(cfg[8]), 64'd4);
    req = '0;
    rel[2] = 1'b1; rel[4] = 1'b1;
    tick();
    rel = '0;

    // Random legal traffic.
    for (int c = 0; c < 300; c++) begin
      gen_random();
      tick();
    end

    // Drain, allocate outputs 6 and 8, then reset mid-operation with a request pending.
    req = '0;
    rel = '1;
    tick();
    rel = '0;
    tick();
    req[0] = 5'b01000; req[2] = 5'b10000;
    tick();
    chk("t6_vld6", 64'(cfg_vld[6]), 64'd1);
    chk("t6_vld8", 64'(cfg_vld[8]), 64'd1);
    req = '0;
    req[5] = 5'b00001;
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_vld", 64'(cfg_vld), 64'd0);
    chk("t6_async_ack", 64'(ack), 64'd0);
    model_reset();
    #1 rst_n = 1'b1;
    tick();
    chk("t6_regrant", 64'(ack), 64'h020);
    req = '0;
    tick();

    // Illegal requests.
    req[1] = 5'b00101;
    tick();
    chk("t5_multi_ack", 64'(ack), 64'd0);
    chk("t5_multi_err", 64'(err), 64'd1);
    req = '0;
    req[2] = 5'b00010;
    tick();
`ifdef SDM_ALLOC_UTURN_EN
    chk("t5_uturn_ack", 64'(ack), 64'h004);
    chk("t5_uturn_cfg2", 64'(cfg[2]), 64'd2);
`else
    chk("t5_uturn_ack", 64'(ack), 64'h000);
`endif
    chk("t5_err_sticky", 64'(err), 64'd1);
    req = '0;

    // Random traffic including multi-hot and U-turn requests.
    bad_ok = 1'b1;
    for (int c = 0; c < 300; c++) begin
      gen_random();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
